// File: rtl/memport_pkg.sv
// rtl/memport_pkg.sv - shared encodings and helpers for the memport client-port initiator
package memport_pkg;

  // Transfer state machine encodings (3 bits)
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_HOLD   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  // Chip selects and output enable are active-low on the client port
  localparam logic CS_ON    = 1'b0;
  localparam logic CS_OFF   = 1'b1;
  localparam logic OE_ON    = 1'b0;
  localparam logic OE_OFF   = 1'b1;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam int CNT_W = 8;

  // Phase counter counts down to zero, so an N-cycle phase loads N-1
  function automatic logic [CNT_W-1:0] phase_load_val(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/memport_waitcnt.sv
// rtl/memport_waitcnt.sv - SETUP/HOLD phase down-counter and rdy wait/timeout counter
module memport_waitcnt
  import memport_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phase_load_i,
  input  logic [CNT_W-1:0] phase_val_i,
  input  logic             phase_dec_i,
  input  logic             wait_clr_i,
  input  logic             wait_inc_i,
  output logic             phase_done_o,
  output logic             timeout_o
);

  // The edge that sees the TIMEOUT-th rdy=0 cycle is the one that gives up
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] phase_q;
  logic [CNT_W-1:0] wait_q;

  // Phase counter: loaded on phase entry, counts down to zero and stops there
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else if (phase_load_i) begin
      phase_q <= phase_val_i;
    end else if (phase_dec_i && (phase_q != '0)) begin
      phase_q <= phase_q - 1'b1;
    end
  end

  // Wait counter: cleared on ACCESS entry, counts rdy=0 cycles, saturates instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= '0;
    end else if (wait_clr_i) begin
      wait_q <= '0;
    end else if (wait_inc_i && (wait_q != {CNT_W{1'b1}})) begin
      wait_q <= wait_q + 1'b1;
    end
  end

  assign phase_done_o = (phase_q == '0);
  assign timeout_o    = (wait_q >= TO_LIM);

endmodule

// File: rtl/memport_master.sv
// rtl/memport_master.sv - single-word request/ack core port to timed memmux client-port cycle
module memport_master
  import memport_pkg::*;
#(
  parameter logic [15:0] FLASH_BASE = 16'h8000,
  parameter int          SETUP_CYC  = 1,
  parameter int          HOLD_CYC   = 1,
  parameter int          TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic [15:0] mem_addr,
  inout  wire  [15:0] mem_data,
  output logic        mem_flcs,
  output logic        mem_ramcs,
  output logic        mem_memoe,
  output logic        mem_memrw,
  input  logic        mem_rdy
);

  localparam logic [CNT_W-1:0] SETUP_LD = phase_load_val(SETUP_CYC);
  localparam logic [CNT_W-1:0] HOLD_LD  = phase_load_val(HOLD_CYC);

  state_e      state_q;
  logic        we_q;
  logic [15:0] wdata_q;
  logic        drv_q;
  logic [15:0] rdata_q;
  logic        ack_q;
  logic        err_q;
  logic        busy_q;
  logic [15:0] addr_q;
  logic        flcs_q;
  logic        ramcs_q;
  logic        oe_q;
  logic        rw_q;

  logic             flash_hit;
  logic             accept;
  logic             phase_load;
  logic [CNT_W-1:0] phase_val;
  logic             phase_dec;
  logic             wait_clr;
  logic             wait_inc;
  logic             phase_done;
  logic             timeout;

  assign flash_hit = (addr >= FLASH_BASE);
  // DONE takes a new request like IDLE does, so held req gives one transfer per 4 cycles
  assign accept    = req && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign phase_dec = (state_q == S_SETUP) || (state_q == S_HOLD);
  assign wait_clr  = (state_q == S_SETUP) && phase_done;
  assign wait_inc  = (state_q == S_ACCESS) && !mem_rdy;

  // Phase counter loads SETUP length on accept and HOLD length when ACCESS completes
  always_comb begin
    phase_load = 1'b0;
    phase_val  = SETUP_LD;
    if (accept) begin
      phase_load = 1'b1;
    end else if ((state_q == S_ACCESS) && mem_rdy) begin
      phase_load = 1'b1;
      phase_val  = HOLD_LD;
    end
  end

  memport_waitcnt #(
    .TIMEOUT(TIMEOUT)
  ) u_waitcnt (
    .clk         (clk),
    .rst         (rst),
    .phase_load_i(phase_load),
    .phase_val_i (phase_val),
    .phase_dec_i (phase_dec),
    .wait_clr_i  (wait_clr),
    .wait_inc_i  (wait_inc),
    .phase_done_o(phase_done),
    .timeout_o   (timeout)
  );

  // Transfer FSM with every bus and core output registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      wdata_q <= '0;
      drv_q   <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      flcs_q  <= CS_OFF;
      ramcs_q <= CS_OFF;
      oe_q    <= OE_OFF;
      rw_q    <= RW_READ;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          flcs_q  <= CS_OFF;
          ramcs_q <= CS_OFF;
          oe_q    <= OE_OFF;
          rw_q    <= RW_READ;
          drv_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (req) begin
            we_q    <= we;
            wdata_q <= wdata;
            busy_q  <= 1'b1;
            if (we && flash_hit) begin
              // Flash is read-only from this port: reject without any bus cycle
              state_q <= S_ERR;
            end else begin
              state_q <= S_SETUP;
              addr_q  <= addr;
              flcs_q  <= flash_hit ? CS_ON : CS_OFF;
              ramcs_q <= flash_hit ? CS_OFF : CS_ON;
              rw_q    <= we ? RW_WRITE : RW_READ;
              drv_q   <= we;
            end
          end
        end
        S_SETUP: begin
          if (phase_done) begin
            state_q <= S_ACCESS;
            oe_q    <= we_q ? OE_OFF : OE_ON;
          end
        end
        S_ACCESS: begin
          if (mem_rdy) begin
            state_q <= S_HOLD;
            oe_q    <= OE_OFF;
            if (!we_q) begin
              rdata_q <= mem_data;
            end
          end else if (timeout) begin
            state_q <= S_ERR;
            flcs_q  <= CS_OFF;
            ramcs_q <= CS_OFF;
            oe_q    <= OE_OFF;
            rw_q    <= RW_READ;
            drv_q   <= 1'b0;
          end
        end
        S_HOLD: begin
          if (phase_done) begin
            state_q <= S_DONE;
            ack_q   <= 1'b1;
            flcs_q  <= CS_OFF;
            ramcs_q <= CS_OFF;
            rw_q    <= RW_READ;
            drv_q   <= 1'b0;
          end
        end
        S_ERR: begin
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_data  = drv_q ? wdata_q : 16'hzzzz;
  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mem_addr  = addr_q;
  assign mem_flcs  = flcs_q;
  assign mem_ramcs = ramcs_q;
  assign mem_memoe = oe_q;
  assign mem_memrw = rw_q;

endmodule
